// File: rtl/memoria_dados_pkg.sv
// memoria_dados_pkg: shared sizes and types for the data memory
package memoria_dados_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 16;
  localparam int NUM_WORDS = 128;
  localparam int WORD_INDEX_BITS = $clog2(NUM_WORDS);
  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [WORD_INDEX_BITS-1:0] idx_t;
endpackage

// File: rtl/memoria_dados_if.sv
// memoria_dados_if: load/store bus between the memory stage and the data memory
interface memoria_dados_if;
  import memoria_dados_pkg::*;
  logic permisao_escrita;
  logic permisao_leitura;
  addr_t endereco;
  word_t dado_escrita;
  word_t dado_leitura;
  modport master (
    output permisao_escrita, permisao_leitura, endereco, dado_escrita,
    input dado_leitura
  );
  modport slave (
    input permisao_escrita, permisao_leitura, endereco, dado_escrita,
    output dado_leitura
  );
endinterface

// File: rtl/memoria_dados_decod.sv
// decod_endereco_dados: byte address to word index; bit 0 and bits above the decoded range are dropped
module decod_endereco_dados
  import memoria_dados_pkg::*;
(
  input  addr_t endereco,
  output idx_t  indice
);
  logic unused_bits;
  assign unused_bits = ^{endereco[ADDR_WIDTH-1:WORD_INDEX_BITS+1], endereco[0]};
  assign indice = endereco[WORD_INDEX_BITS:1];
endmodule

// File: rtl/memoria_dados.sv
// memoria_dados: 128x16 data memory, synchronous write, gated combinational read, async clear
module memoria_dados
  import memoria_dados_pkg::*;
(
  input logic clock,
  input logic reset_n,
  memoria_dados_if.slave bus
);
  idx_t indice;
  word_t mem_q [NUM_WORDS];
  word_t mem_d [NUM_WORDS];
  decod_endereco_dados u_decod (
    .endereco(bus.endereco),
    .indice(indice)
  );
  // next storage contents: one addressed word replaced when writing
  always_comb begin
    mem_d = mem_q;
    if (bus.permisao_escrita) mem_d[indice] = bus.dado_escrita;
  end
  // storage: reset wipes every word at once, otherwise take the next contents
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end
  assign bus.dado_leitura = bus.permisao_leitura ? mem_q[indice] : '0;
endmodule

// File: tb/tb_memoria_dados.sv
// tb_memoria_dados: directed plus random checks of the data memory against an array model
module tb_memoria_dados;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [15:0] ref_mem [128];
  memoria_dados_if bus ();
  memoria_dados dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clock = ~clock;
  function automatic int word_of(input logic [15:0] a);
    return (int'(a) % 256) / 2;
  endfunction
  function automatic logic [15:0] expected_read(input logic [15:0] a, input logic re);
    return re ? ref_mem[word_of(a)] : 16'h0000;
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic clear_model();
    for (int i = 0; i < 128; i++) ref_mem[i] = 16'h0000;
  endtask
  task automatic write_word(input logic [15:0] a, input logic [15:0] d);
    @(negedge clock);
    bus.permisao_escrita = 1'b1;
    bus.endereco = a;
    bus.dado_escrita = d;
    @(posedge clock);
    ref_mem[word_of(a)] = d;
    #1 bus.permisao_escrita = 1'b0;
  endtask
  task automatic read_sweep(input string tag);
    @(negedge clock);
    bus.permisao_escrita = 1'b0;
    bus.permisao_leitura = 1'b1;
    for (int a = 0; a < 256; a += 2) begin
      bus.endereco = 16'(a);
      #1 chk(tag, bus.dado_leitura, expected_read(16'(a), 1'b1));
    end
  endtask
  initial begin
    clear_model();
    bus.permisao_escrita = 1'b0;
    bus.permisao_leitura = 1'b0;
    bus.endereco = 16'h0000;
    bus.dado_escrita = 16'h0000;
    // reset then scan
    #12 reset_n = 1'b1;
    #1 chk("idle_out", bus.dado_leitura, 16'h0000);
    read_sweep("reset_scan");
    // write sweep then read back
    for (int a = 0; a < 256; a += 2) write_word(16'(a), 16'(a));
    read_sweep("sweep_read");
    // read gating
    @(negedge clock);
    bus.permisao_leitura = 1'b0;
    bus.endereco = 16'd10;
    #1 chk("gate_off", bus.dado_leitura, 16'h0000);
    bus.permisao_leitura = 1'b1;
    #1 chk("gate_on", bus.dado_leitura, 16'd10);
    // same-cycle read and write
    @(negedge clock);
    bus.permisao_escrita = 1'b1;
    bus.endereco = 16'd4;
    bus.dado_escrita = 16'hABCD;
    #1 chk("rw_before", bus.dado_leitura, 16'd4);
    @(posedge clock);
    ref_mem[word_of(16'd4)] = 16'hABCD;
    #1 chk("rw_after", bus.dado_leitura, 16'hABCD);
    bus.permisao_escrita = 1'b0;
    // aliasing and write-disable
    write_word(16'd6, 16'h1234);
    bus.endereco = 16'd7;
    #1 chk("alias_odd", bus.dado_leitura, 16'h1234);
    bus.endereco = 16'd262;
    #1 chk("alias_wrap", bus.dado_leitura, 16'h1234);
    @(negedge clock);
    bus.endereco = 16'd6;
    bus.dado_escrita = 16'h5555;
    @(posedge clock);
    #1 chk("no_write", bus.dado_leitura, 16'h1234);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      bus.permisao_escrita = 1'($urandom_range(0, 1));
      bus.permisao_leitura = 1'($urandom_range(0, 1));
      bus.endereco = 16'($urandom);
      bus.dado_escrita = 16'($urandom);
      #1 chk("rand_pre", bus.dado_leitura, expected_read(bus.endereco, bus.permisao_leitura));
      @(posedge clock);
      if (bus.permisao_escrita) ref_mem[word_of(bus.endereco)] = bus.dado_escrita;
      #1 chk("rand_post", bus.dado_leitura, expected_read(bus.endereco, bus.permisao_leitura));
    end
    // async reset with a write pending
    write_word(16'd20, 16'hBEEF);
    @(negedge clock);
    bus.permisao_leitura = 1'b1;
    bus.permisao_escrita = 1'b1;
    bus.endereco = 16'd20;
    bus.dado_escrita = 16'h7777;
    #1 chk("pre_reset", bus.dado_leitura, 16'hBEEF);
    #1 reset_n = 1'b0;
    clear_model();
    #1 chk("reset_now", bus.dado_leitura, 16'h0000);
    @(posedge clock);
    #1 chk("reset_hold", bus.dado_leitura, 16'h0000);
    @(negedge clock);
    bus.permisao_escrita = 1'b0;
    #1 reset_n = 1'b1;
    #1 chk("post_reset", bus.dado_leitura, 16'h0000);
    read_sweep("reset_sweep");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
